hilo_muldiv_seq: RTL and testbench

- Sequential multiply/divide engine and HI/LO register pair for the multi-cycle MIPS core.
- Accepts MULT/MULTU/DIV/DIVU operands from the ALU operand path and writes the 64-bit result into architectural HI/LO.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- Uses a start/busy/done handshake, so the controller stalls instead of relying on a single-cycle combinational multiplier/divider.

---
 rtl/hilo_muldiv_if.sv | 39 +++
 rtl/hilo_muldiv_seq.sv | 178 +++++++++++++++++
 tb/tb_hilo_muldiv_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_if.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_if
//   Controller <-> HI/LO multiply/divide engine bundle.
//   master : the pipeline controller (drives launch, operands, MTHI/MTLO writes)
//   slave  : hilo_muldiv_seq (returns busy/done and the HI/LO registers)
//   Signals:
//     start     launch request, sampled only while the engine is idle
//     op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     a, b      rs / rt operands
//     hi_wr_en  MTHI strobe, lo_wr_en MTLO strobe, wr_data their data
//     busy      operation in flight
//     done      one-cycle pulse when an operation updates HI/LO
//     hi, lo    architectural HI/LO registers
// -----------------------------------------------------------------------------
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_wr_en;
    logic             lo_wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_wr_en, lo_wr_en, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_wr_en, lo_wr_en, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_seq.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_seq
//   Sequential radix-2 multiply/divide engine with the architectural HI/LO
//   register pair of the multi-cycle MIPS core.
//   - MULT/MULTU: shift-add, DIV/DIVU: restoring shift-subtract, both on
//     operand magnitudes with a sign fix-up in the final FIX cycle.
//   - Latency: WIDTH+1 edges from accept to HI/LO write; busy high WIDTH+1
//     cycles, done pulses the cycle after the write.
//   - MTHI/MTLO writes are accepted only while idle.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (aborts any operation)
//   bus      hilo_muldiv_if.slave (start/op/a/b, MTHI/MTLO, busy/done/hi/lo)
// Parameters:
//   WIDTH    operand width, even and >= 8
// Build option:
//   HILO_DIVZERO_FAST_EN  when defined, DIV/DIVU by zero writes back at the
//                         accept edge without ever raising busy.
// -----------------------------------------------------------------------------
module hilo_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    hilo_muldiv_if.slave  bus
);
    localparam int                CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    state_t             state, state_nxt;
    op_t                op_q;
    logic [WIDTH-1:0]   md;        // multiplicand (mul) or divisor (div) magnitude
    logic [WIDTH-1:0]   mr;        // multiplier (mul, shifts right) or dividend (div, shifts left)
    logic [WIDTH-1:0]   a_raw;     // original rs, returned in HI on divide by zero
    logic [2*WIDTH-1:0] acc;       // mul: {partial hi, product lo}; div: {remainder, quotient}
    logic [CNT_W-1:0]   counter;
    logic               neg_q, neg_r;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    // Launch-time operand conditioning
    logic               signed_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               fast_dz;

    assign signed_op = ~bus.op[0];
    assign a_mag     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

`ifdef HILO_DIVZERO_FAST_EN
    assign fast_dz = bus.op[1] && (bus.b == '0);
`else
    assign fast_dz = 1'b0;
`endif

    // One radix-2 step for each operation class
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0]   rem_sh, rem_nxt;
    logic               rem_ge;
    logic [2*WIDTH-1:0] div_acc;

    assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mr[0] ? {1'b0, md} : '0);
    assign mul_acc = {add_sum, acc[WIDTH-1:1]};

    // The bit shifted out of the remainder top acts as a carry: with it set
    // the shifted remainder exceeds any WIDTH-bit divisor.
    assign rem_sh  = {acc[2*WIDTH-2:WIDTH], mr[WIDTH-1]};
    assign rem_ge  = acc[2*WIDTH-1] | (rem_sh >= md);
    assign rem_nxt = rem_ge ? rem_sh - md : rem_sh;
    assign div_acc = {rem_nxt, acc[WIDTH-2:0], rem_ge};

    // FIX-cycle sign correction
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign prod = (op_q == OP_MULT && neg_q) ? -acc : acc;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (op_q[1]) begin
            if (md == '0) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_lo = (op_q == OP_DIV && neg_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                res_hi = (op_q == OP_DIV && neg_r) ? -acc[2*WIDTH-1:WIDTH]
                                                   : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    // FSM
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = fast_dz ? IDLE : CALC;
            CALC:    if (counter == LAST_STEP) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Datapath and HI/LO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= OP_MULT;
            md      <= '0;
            mr      <= '0;
            a_raw   <= '0;
            acc     <= '0;
            counter <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.hi_wr_en) hi_q <= bus.wr_data;
                    if (bus.lo_wr_en) lo_q <= bus.wr_data;
                    if (bus.start) begin
                        op_q    <= op_t'(bus.op);
                        md      <= bus.op[1] ? b_mag : a_mag;
                        mr      <= bus.op[1] ? a_mag : b_mag;
                        a_raw   <= bus.a;
                        neg_q   <= signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r   <= signed_op & bus.a[WIDTH-1];
                        acc     <= '0;
                        counter <= '0;
                        // Divide-by-zero shortcut overrides a coincident MTHI/MTLO
                        if (fast_dz) begin
                            hi_q   <= bus.a;
                            lo_q   <= '1;
                            done_q <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    acc     <= op_q[1] ? div_acc : mul_acc;
                    mr      <= op_q[1] ? (mr << 1) : (mr >> 1);
                    counter <= (counter == LAST_STEP) ? '0 : counter + 1'b1;
                end
                FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_hilo_muldiv_seq
//   Directed self-checking bench for hilo_muldiv_seq (WIDTH=32). Expected
//   values are hand-computed constants. Outputs are sampled on the falling
//   edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_hilo_muldiv_seq;
    localparam int W         = 32;
    localparam int BUSY_CYC  = W + 1;   // busy high cycles for a normal op
    localparam int DONE_IDX  = W + 2;   // falling edge (counted from E0) showing done
    localparam int WINDOW    = W + 6;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    hilo_muldiv_if #(.WIDTH(W)) bus ();

    hilo_muldiv_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one op at a falling edge; the next rising edge is E0. Watches a
    // fixed window of falling edges (index 1 = the cycle after E0). When
    // inject_at is non-zero a second start plus an MTLO write are pulsed at
    // that index to show they are dropped while busy.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_at,
                          output int busy_cnt, output int done_cnt, output int first_done,
                          output logic [W-1:0] hi_mid, output logic [W-1:0] lo_mid);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        busy_cnt   = 0;
        done_cnt   = 0;
        first_done = 0;
        hi_mid     = '0;
        lo_mid     = '0;
        for (int i = 1; i <= WINDOW; i++) begin
            @(negedge clk);
            bus.start    = 1'b0;
            bus.lo_wr_en = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (first_done == 0) first_done = i;
            end
            if (i == 10) begin
                hi_mid = bus.hi;
                lo_mid = bus.lo;
            end
            if (i == inject_at) begin
                bus.start    = 1'b1;
                bus.lo_wr_en = 1'b1;
                bus.wr_data  = 32'h0000_DEAD;
                bus.op       = 2'b11;
                bus.a        = 32'h0000_0050;
                bus.b        = 32'h0000_0000;
            end
        end
    endtask

    task automatic check_op(input string tag, input logic [1:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                            input int exp_busy, input int exp_done_idx, input int inject_at);
        int busy_cnt, done_cnt, first_done;
        logic [W-1:0] hi_pre, lo_pre, hi_mid, lo_mid;
        hi_pre = bus.hi;
        lo_pre = bus.lo;
        run_op(op, a, b, inject_at, busy_cnt, done_cnt, first_done, hi_mid, lo_mid);
        check({tag, "_hi"},       64'(bus.hi),     64'(exp_hi));
        check({tag, "_lo"},       64'(bus.lo),     64'(exp_lo));
        check({tag, "_busy_cyc"}, 64'(busy_cnt),   64'(exp_busy));
        check({tag, "_done_at"},  64'(first_done), 64'(exp_done_idx));
        check({tag, "_done_cnt"}, 64'(done_cnt),   64'd1);
        if (exp_busy != 0) begin
            check({tag, "_hold_hi"}, 64'(hi_mid), 64'(hi_pre));
            check({tag, "_hold_lo"}, 64'(lo_mid), 64'(lo_pre));
        end
    endtask

    int dz_busy, dz_done;
    int done_seen;

    initial begin
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.a        = '0;
        bus.b        = '0;
        bus.hi_wr_en = 1'b0;
        bus.lo_wr_en = 1'b0;
        bus.wr_data  = '0;

`ifdef HILO_DIVZERO_FAST_EN
        dz_busy = 0;
        dz_done = 1;
`else
        dz_busy = BUSY_CYC;
        dz_done = DONE_IDX;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hi",   64'(bus.hi),   64'd0);
        check("rst_lo",   64'(bus.lo),   64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        reset_n = 1'b1;

        // MTHI in idle
        @(negedge clk);
        bus.hi_wr_en = 1'b1;
        bus.wr_data  = 32'hAAAA_5555;
        @(negedge clk);
        bus.hi_wr_en = 1'b0;
        check("mthi_hi", 64'(bus.hi), 64'h0000_0000_AAAA_5555);
        check("mthi_lo", 64'(bus.lo), 64'd0);

        // MTHI+MTLO together
        bus.hi_wr_en = 1'b1;
        bus.lo_wr_en = 1'b1;
        bus.wr_data  = 32'h1357_9BDF;
        @(negedge clk);
        bus.hi_wr_en = 1'b0;
        bus.lo_wr_en = 1'b0;
        check("mtboth_hi", 64'(bus.hi), 64'h0000_0000_1357_9BDF);
        check("mtboth_lo", 64'(bus.lo), 64'h0000_0000_1357_9BDF);

        // Arithmetic
        check_op("mult_neg3x7",   2'b00, 32'hFFFF_FFFD, 32'h0000_0007,
                 32'hFFFF_FFFF, 32'hFFFF_FFEB, BUSY_CYC, DONE_IDX, 0);
        check_op("multu_max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'hFFFF_FFFE, 32'h0000_0001, BUSY_CYC, DONE_IDX, 0);
        check_op("mult_intmin",   2'b00, 32'h8000_0000, 32'h0000_0002,
                 32'hFFFF_FFFF, 32'h0000_0000, BUSY_CYC, DONE_IDX, 0);
        check_op("divu_100_7",    2'b11, 32'd100, 32'd7,
                 32'h0000_0002, 32'h0000_000E, BUSY_CYC, DONE_IDX, 0);
        check_op("div_neg7_2",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002,
                 32'hFFFF_FFFF, 32'hFFFF_FFFD, BUSY_CYC, DONE_IDX, 0);
        check_op("div_ovf",       2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
                 32'h0000_0000, 32'h8000_0000, BUSY_CYC, DONE_IDX, 0);
        check_op("divu_bigdiv",   2'b11, 32'hFFFF_FFFF, 32'h8000_0001,
                 32'h7FFF_FFFE, 32'h0000_0001, BUSY_CYC, DONE_IDX, 0);
        check_op("div_by0",       2'b10, 32'h1234_5678, 32'h0000_0000,
                 32'h1234_5678, 32'hFFFF_FFFF, dz_busy, dz_done, 0);
        check_op("div_neg_by0",   2'b10, 32'hFFFF_FFF0, 32'h0000_0000,
                 32'hFFFF_FFF0, 32'hFFFF_FFFF, dz_busy, dz_done, 0);

        // Start and MTLO while busy are dropped
        check_op("multu_inject",  2'b01, 32'd2, 32'd3,
                 32'h0000_0000, 32'h0000_0006, BUSY_CYC, DONE_IDX, 5);

        // Preload HI/LO, then abort a DIVU with reset at E10
        bus.hi_wr_en = 1'b1;
        bus.lo_wr_en = 1'b1;
        bus.wr_data  = 32'h5A5A_5A5A;
        @(negedge clk);
        bus.hi_wr_en = 1'b0;
        bus.lo_wr_en = 1'b0;
        bus.op    = 2'b11;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);                 // E0
        #1 bus.start = 1'b0;
        check("abort_busy_pre", 64'(bus.busy), 64'd1);
        repeat (10) @(posedge clk);     // E10
        #1 reset_n = 1'b0;
        #1;
        check("abort_hi",   64'(bus.hi),   64'd0);
        check("abort_lo",   64'(bus.lo),   64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        done_seen = 0;
        for (int i = 0; i < WINDOW; i++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("abort_no_done",   64'(done_seen), 64'd0);
        check("abort_idle_busy", 64'(bus.busy),  64'd0);

        check_op("divu_9_4", 2'b11, 32'd9, 32'd4,
                 32'h0000_0001, 32'h0000_0002, BUSY_CYC, DONE_IDX, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
